// File: rtl/stdp_scheduler.sv
// STDP learning scheduler: N_SYN synapses share one 8-bit saturating add/sub unit.
// Events are latched as pending flags and serviced one at a time from IDLE.
module stdp_scheduler #(
   parameter int unsigned N_SYN       = 4,
   parameter logic [7:0]  TRACE_INC   = 8'd32,
   parameter int unsigned DECAY_SHIFT = 2,
   parameter logic [7:0]  W_INIT      = 8'd64
) (
   input  logic               clk,
   input  logic               reset,
   input  logic [N_SYN-1:0]   pre_spike,
   input  logic               post_spike,
   input  logic               learn,
   input  logic               tick,
   output logic               busy,
   output logic               act_valid,
   output logic [1:0]         act_idx,
   output logic [7:0]         act_data,
   output logic [8*N_SYN-1:0] weight_out
);

   localparam int unsigned IW = (N_SYN > 1) ? $clog2(N_SYN) : 1;
   localparam int unsigned CW = $clog2(N_SYN + 1);
   localparam logic [CW-1:0] LtpLast   = CW'(N_SYN - 1);
   localparam logic [CW-1:0] DecayLast = CW'(N_SYN);
   localparam logic [IW-1:0] IdxLast   = IW'(N_SYN - 1);

   typedef enum logic [2:0] {
      StIdle,
      StPostLtp,
      StPostTr,
      StPreLtd,
      StPreTr,
      StDecay
   } state_e;

   state_e           state_q, state_d;
   logic [7:0]       pre_trace_q [N_SYN];
   logic [7:0]       pre_trace_d [N_SYN];
   logic [7:0]       weight_q [N_SYN];
   logic [7:0]       weight_d [N_SYN];
   logic [7:0]       post_trace_q, post_trace_d;
   logic [N_SYN-1:0] pend_pre_q, pend_pre_d;
   logic             pend_post_q, pend_post_d;
   logic             pend_tick_q, pend_tick_d;
   logic [IW-1:0]    rr_ptr_q, rr_ptr_d;
   logic [IW-1:0]    sel_q, sel_d;
   logic [CW-1:0]    cnt_q, cnt_d;
   logic             act_valid_q, act_valid_d;
   logic [1:0]       act_idx_q, act_idx_d;
   logic [7:0]       act_data_q, act_data_d;

   logic [IW-1:0]    k_idx;
   logic [IW-1:0]    wr_idx;
   logic             pre_any;
   logic [IW-1:0]    pre_pick;
   logic [IW-1:0]    cand;
   logic [7:0]       alu_a, alu_b, alu_res;
   logic             alu_sub;
   logic [8:0]       alu_sum;
   logic             wr_weight, wr_pre, wr_post;
   logic [N_SYN-1:0] clr_pre;
   logic             clr_post, clr_tick;

   assign k_idx = cnt_q[IW-1:0];

   // Round-robin search starting at rr_ptr_q; first pending index found wins.
   always_comb begin
      pre_any  = 1'b0;
      pre_pick = rr_ptr_q;
      cand     = '0;
      for (int unsigned off = 0; off < N_SYN; off++) begin
         cand = IW'((32'(rr_ptr_q) + off) % N_SYN);
         if (!pre_any && pend_pre_q[cand]) begin
            pre_any  = 1'b1;
            pre_pick = cand;
         end
      end
   end

   // FSM state register
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q <= StIdle;
      end else begin
         state_q <= state_d;
      end
   end

   // FSM next-state, including the service counter and arbitration bookkeeping
   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      sel_d    = sel_q;
      rr_ptr_d = rr_ptr_q;
      unique case (state_q)
         StIdle: begin
            if (pend_post_q) begin
               state_d = StPostLtp;
               cnt_d   = '0;
            end else if (pre_any) begin
               state_d  = StPreLtd;
               sel_d    = pre_pick;
               rr_ptr_d = (pre_pick == IdxLast) ? '0 : pre_pick + 1'b1;
            end else if (pend_tick_q) begin
               state_d = StDecay;
               cnt_d   = '0;
            end
         end
         StPostLtp: begin
            if (cnt_q == LtpLast) begin
               state_d = StPostTr;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         StPostTr: state_d = StIdle;
         StPreLtd: state_d = StPreTr;
         StPreTr:  state_d = StIdle;
         StDecay: begin
            if (cnt_q == DecayLast) begin
               state_d = StIdle;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         default: state_d = StIdle;
      endcase
   end

   // FSM outputs: operand selection and write enables for the shared unit
   always_comb begin
      busy      = (state_q != StIdle);
      alu_a     = '0;
      alu_b     = '0;
      alu_sub   = 1'b0;
      wr_idx    = k_idx;
      wr_weight = 1'b0;
      wr_pre    = 1'b0;
      wr_post   = 1'b0;
      clr_pre   = '0;
      clr_post  = 1'b0;
      clr_tick  = 1'b0;
      unique case (state_q)
         StIdle: ;
         StPostLtp: begin
            alu_a     = weight_q[k_idx];
            alu_b     = pre_trace_q[k_idx] >> 2;
            wr_weight = learn;
         end
         StPostTr: begin
            alu_a    = post_trace_q;
            alu_b    = TRACE_INC;
            wr_post  = 1'b1;
            clr_post = 1'b1;
         end
         StPreLtd: begin
            wr_idx    = sel_q;
            alu_a     = weight_q[sel_q];
            alu_b     = post_trace_q >> 2;
            alu_sub   = 1'b1;
            wr_weight = learn;
         end
         StPreTr: begin
            wr_idx         = sel_q;
            alu_a          = pre_trace_q[sel_q];
            alu_b          = TRACE_INC;
            wr_pre         = 1'b1;
            clr_pre[sel_q] = 1'b1;
         end
         StDecay: begin
            alu_sub = 1'b1;
            if (cnt_q == DecayLast) begin
               alu_a    = post_trace_q;
               alu_b    = post_trace_q >> DECAY_SHIFT;
               wr_post  = 1'b1;
               clr_tick = 1'b1;
            end else begin
               alu_a  = pre_trace_q[k_idx];
               alu_b  = pre_trace_q[k_idx] >> DECAY_SHIFT;
               wr_pre = 1'b1;
            end
         end
         default: ;
      endcase
   end

   // Shared 8-bit unit; bit 8 of the 9-bit result flags overflow or borrow.
   always_comb begin
      alu_sum = alu_sub ? ({1'b0, alu_a} - {1'b0, alu_b}) : ({1'b0, alu_a} + {1'b0, alu_b});
      if (alu_sum[8]) begin
         alu_res = alu_sub ? 8'd0 : 8'hff;
      end else begin
         alu_res = alu_sum[7:0];
      end
   end

   // Datapath next-state; a new event sets its flag even on the edge that clears it.
   always_comb begin
      for (int unsigned i = 0; i < N_SYN; i++) begin
         pre_trace_d[i] = pre_trace_q[i];
         weight_d[i]    = weight_q[i];
      end
      post_trace_d = post_trace_q;
      if (wr_pre) begin
         pre_trace_d[wr_idx] = alu_res;
      end
      if (wr_weight) begin
         weight_d[wr_idx] = alu_res;
      end
      if (wr_post) begin
         post_trace_d = alu_res;
      end
      pend_pre_d  = (pend_pre_q & ~clr_pre) | pre_spike;
      pend_post_d = (pend_post_q & ~clr_post) | post_spike;
      pend_tick_d = (pend_tick_q & ~clr_tick) | tick;
      act_valid_d = (state_q == StPreLtd);
      act_idx_d   = act_idx_q;
      act_data_d  = act_data_q;
      if (state_q == StPreLtd) begin
         act_idx_d  = 2'(sel_q);
         act_data_d = weight_q[sel_q];
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         for (int unsigned i = 0; i < N_SYN; i++) begin
            pre_trace_q[i] <= '0;
            weight_q[i]    <= W_INIT;
         end
         post_trace_q <= '0;
         pend_pre_q   <= '0;
         pend_post_q  <= 1'b0;
         pend_tick_q  <= 1'b0;
         rr_ptr_q     <= '0;
         sel_q        <= '0;
         cnt_q        <= '0;
         act_valid_q  <= 1'b0;
         act_idx_q    <= '0;
         act_data_q   <= '0;
      end else begin
         for (int unsigned i = 0; i < N_SYN; i++) begin
            pre_trace_q[i] <= pre_trace_d[i];
            weight_q[i]    <= weight_d[i];
         end
         post_trace_q <= post_trace_d;
         pend_pre_q   <= pend_pre_d;
         pend_post_q  <= pend_post_d;
         pend_tick_q  <= pend_tick_d;
         rr_ptr_q     <= rr_ptr_d;
         sel_q        <= sel_d;
         cnt_q        <= cnt_d;
         act_valid_q  <= act_valid_d;
         act_idx_q    <= act_idx_d;
         act_data_q   <= act_data_d;
      end
   end

   assign act_valid = act_valid_q;
   assign act_idx   = act_idx_q;
   assign act_data  = act_data_q;

   always_comb begin
      for (int unsigned i = 0; i < N_SYN; i++) begin
         weight_out[8*i +: 8] = weight_q[i];
      end
   end

endmodule

// File: tb/tb_stdp_scheduler.sv
// Scoreboard bench for stdp_scheduler: expected activations and post-service weights are
// queued with the stimulus and checked by a monitor on act_valid and on each busy fall.
module tb_stdp_scheduler;

   logic        clk;
   logic        reset;
   logic [3:0]  pre_spike;
   logic        post_spike;
   logic        learn;
   logic        tick;
   logic        busy;
   logic        act_valid;
   logic [1:0]  act_idx;
   logic [7:0]  act_data;
   logic [31:0] weight_out;

   int checks;
   int failures;

   logic [9:0]  act_q [$];
   logic [31:0] w_q [$];

   localparam logic [31:0] WAll64 = 32'h4040_4040;

   stdp_scheduler dut (
      .clk        (clk),
      .reset      (reset),
      .pre_spike  (pre_spike),
      .post_spike (post_spike),
      .learn      (learn),
      .tick       (tick),
      .busy       (busy),
      .act_valid  (act_valid),
      .act_idx    (act_idx),
      .act_data   (act_data),
      .weight_out (weight_out)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s: got %0h, expected %0h", name, got, exp);
      end
   endtask

   task automatic pulse(input logic [3:0] pre, input logic post, input logic tk);
      @(negedge clk);
      pre_spike  = pre;
      post_spike = post;
      tick       = tk;
      @(negedge clk);
      pre_spike  = '0;
      post_spike = 1'b0;
      tick       = 1'b0;
   endtask

   task automatic settle(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic do_reset();
      chk("act_queue_drained", act_q.size(), 0);
      chk("w_queue_drained", w_q.size(), 0);
      @(negedge clk);
      reset = 1'b0;
      settle(2);
      reset = 1'b1;
      settle(2);
   endtask

   // Monitor: pops one expected activation per strobe cycle, one weight vector per service end.
   initial begin : monitor
      logic        prev_busy;
      logic [9:0]  ea;
      logic [31:0] ew;
      prev_busy = 1'b0;
      forever begin
         @(negedge clk);
         if (reset) begin
            if (act_valid) begin
               if (act_q.size() == 0) begin
                  checks++;
                  failures++;
                  $display("FAIL act_unexpected: got idx=%0d data=%0d, expected no strobe",
                           act_idx, act_data);
               end else begin
                  ea = act_q.pop_front();
                  chk("act", {22'd0, act_idx, act_data}, {22'd0, ea});
               end
            end
            if (prev_busy && !busy) begin
               if (w_q.size() == 0) begin
                  checks++;
                  failures++;
                  $display("FAIL svc_unexpected: got weights %0h, expected no service", weight_out);
               end else begin
                  ew = w_q.pop_front();
                  chk("weights", weight_out, ew);
               end
            end
         end
         prev_busy = busy && reset;
      end
   end

   initial begin : watchdog
      #200000;
      $display("FAIL watchdog: got no finish, expected finish before time limit");
      $fatal(1, "timeout");
   end

   initial begin : stim
      int found;
      checks     = 0;
      failures   = 0;
      reset      = 1'b0;
      pre_spike  = '0;
      post_spike = 1'b0;
      learn      = 1'b0;
      tick       = 1'b0;
      settle(2);
      chk("rst_busy", busy, 0);
      chk("rst_act_valid", act_valid, 0);
      chk("rst_act_idx", act_idx, 0);
      chk("rst_act_data", act_data, 0);
      chk("rst_weights", weight_out, WAll64);
      reset = 1'b1;
      settle(2);

      // Pre then post on synapse 0
      learn = 1'b1;
      act_q.push_back({2'd0, 8'd64});
      w_q.push_back(WAll64);
      @(negedge clk);
      pre_spike = 4'b0001;
      @(negedge clk);
      pre_spike = '0;
      chk("lat_idle", busy, 0);
      @(negedge clk);
      chk("lat_busy", busy, 1);
      settle(10);
      w_q.push_back(32'h4040_4048);
      pulse(4'b0000, 1'b1, 1'b0);
      settle(12);
      do_reset();

      // Post wins over a same-edge pre
      learn = 1'b1;
      w_q.push_back(WAll64);
      act_q.push_back({2'd1, 8'd64});
      w_q.push_back(32'h4040_3840);
      pulse(4'b0010, 1'b1, 1'b0);
      settle(20);
      do_reset();

      // All synapses spike for 3 edges: merged into one service each, in index order
      learn = 1'b1;
      for (int i = 0; i < 4; i++) begin
         act_q.push_back({2'(i), 8'd64});
         w_q.push_back(WAll64);
      end
      @(negedge clk);
      pre_spike = 4'b1111;
      settle(3);
      pre_spike = '0;
      settle(30);
      do_reset();

      // Trace and weight saturation
      learn = 1'b0;
      for (int i = 0; i < 8; i++) begin
         act_q.push_back({2'd0, 8'd64});
         w_q.push_back(WAll64);
         pulse(4'b0001, 1'b0, 1'b0);
         settle(8);
      end
      learn = 1'b1;
      w_q.push_back(32'h4040_407f);
      pulse(4'b0000, 1'b1, 1'b0);
      settle(10);
      w_q.push_back(32'h4040_40be);
      pulse(4'b0000, 1'b1, 1'b0);
      settle(10);
      w_q.push_back(32'h4040_40fd);
      pulse(4'b0000, 1'b1, 1'b0);
      settle(10);
      w_q.push_back(32'h4040_40ff);
      pulse(4'b0000, 1'b1, 1'b0);
      settle(10);
      do_reset();

      // Decay then LTP, then reset in the middle of a decay
      learn = 1'b0;
      act_q.push_back({2'd0, 8'd64});
      w_q.push_back(WAll64);
      pulse(4'b0001, 1'b0, 1'b0);
      settle(8);
      w_q.push_back(WAll64);
      pulse(4'b0000, 1'b0, 1'b1);
      settle(10);
      learn = 1'b1;
      w_q.push_back(32'h4040_4046);
      pulse(4'b0000, 1'b1, 1'b0);
      settle(10);
      pulse(4'b0000, 1'b0, 1'b1);
      found = 0;
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         if (busy) begin
            found = 1;
            break;
         end
      end
      chk("decay_started", found, 1);
      @(negedge clk);
      chk("pre_abort_busy", busy, 1);
      chk("pre_abort_weights", weight_out, 32'h4040_4046);
      #2;
      reset = 1'b0;
      #1;
      chk("abort_busy", busy, 0);
      chk("abort_act_valid", act_valid, 0);
      chk("abort_act_idx", act_idx, 0);
      chk("abort_act_data", act_data, 0);
      chk("abort_weights", weight_out, WAll64);
      settle(2);
      reset = 1'b1;
      settle(10);
      chk("final_act_queue", act_q.size(), 0);
      chk("final_w_queue", w_q.size(), 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
